datamem_copy_engine: RTL and testbench

- Initiator-side master for the single-port data memory (combinational read, write on clock edge, 16-bit words, 64 locations decoded from Address[5:0]).
- Accepts a copy command (source, destination, length) over a valid/ready handshake and moves words one at a time through the memory port.
- Sits beside the core on the data-memory bus; while it runs, the core must not drive the memory.

---
 rtl/datamem_pkg.sv | 12 +
 rtl/datamem_copy_engine.sv | 107 ++++++++++
 tb/tb_datamem_copy_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
// datamem_pkg: shared constants and FSM state type for the data-memory copy engine
package datamem_pkg;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 64;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;
endpackage

// File: rtl/datamem_copy_engine.sv
// datamem_copy_engine: word-by-word memory copy master; optional running checksum under DATAMEM_COPY_CHECKSUM_EN
module datamem_copy_engine #(
    parameter int DATA_W = datamem_pkg::DATA_W,
    parameter int ADDR_W = datamem_pkg::ADDR_W,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
`ifdef DATAMEM_COPY_CHECKSUM_EN
   ,output logic [DATA_W-1:0] checksum
`endif
);
    import datamem_pkg::*;

    copy_state_t       r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  w_idx_nxt;

    assign w_idx_nxt = r_idx + 1'b1;

    // Copy FSM; memory-port outputs are loaded one edge ahead so they are pure registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            MemWrite  <= 1'b0;
            Address   <= '0;
            WriteData <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_src     <= cmd_src;
                        r_dst     <= cmd_dst;
                        r_len     <= cmd_len;
                        r_idx     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= READ;
                            Address <= cmd_src;
                        end
                    end
                end
                READ: begin
                    WriteData <= ReadData;
                    Address   <= r_dst + ADDR_W'(r_idx);
                    MemWrite  <= 1'b1;
                    r_state   <= WRITE;
                end
                WRITE: begin
                    r_idx    <= w_idx_nxt;
                    MemWrite <= 1'b0;
                    if (w_idx_nxt == r_len) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state <= READ;
                        Address <= r_src + ADDR_W'(w_idx_nxt);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DATAMEM_COPY_CHECKSUM_EN
    // Running sum of every word read; cleared when a new command is taken
    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE && cmd_valid)) begin
            checksum <= '0;
        end else if (r_state == READ) begin
            checksum <= checksum + ReadData;
        end
    end
`endif

endmodule

// File: tb/tb_datamem_copy_engine.sv
// tb_datamem_copy_engine: scoreboard bench for the copy engine against a 64-word bench memory
module tb_datamem_copy_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_src = '0;
    logic [15:0] cmd_dst = '0;
    logic [6:0]  cmd_len = '0;
    logic        busy;
    logic        done;
    logic        MemWrite;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic [15:0] ReadData;
`ifdef DATAMEM_COPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    bit   [15:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int len; int writes; int csum; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int wr_cnt = 0;
    int last_done_cyc = -100;
    bit mon_en = 1'b0;

    datamem_copy_engine dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .MemWrite(MemWrite), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
`ifdef DATAMEM_COPY_CHECKSUM_EN
       ,.checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ReadData = mem[Address[5:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (MemWrite) mem[Address[5:0]] <= WriteData;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input int d);
        pl_en = 1'b1;
        pl_addr = 6'(a);
        pl_data = 16'(d);
        tick();
        pl_en = 1'b0;
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_dn(input int l, input int w, input int c);
        dn_t e;
        e.len = l;
        e.writes = w;
        e.csum = c;
        exp_dn.push_back(e);
    endtask

    task automatic issue(input int s, input int d, input int l);
        cmd_src = 16'(s);
        cmd_dst = 16'(d);
        cmd_len = 7'(l);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && !(cmd_ready && !busy); i++) tick();
        chk("idle_return", int'(cmd_ready && !busy), 1);
    endtask

    // Monitor: pops expected writes and completions as the DUT presents them
    always @(negedge clk) begin
        if (mon_en) begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                wr_cnt = 0;
            end
            if (MemWrite) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", int'(Address[5:0]), -1);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", int'(Address[5:0]), w.addr);
                    chk("wr_data", int'(WriteData), w.data);
                end
            end
            if (done) begin
                last_done_cyc = cyc;
                if (exp_dn.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dn_t e;
                    e = exp_dn.pop_front();
                    chk("done_latency", cyc - acc_cyc, 2 * e.len + 1);
                    chk("write_count", wr_cnt, e.writes);
                    chk("ready_low_in_done", int'(cmd_ready), 0);
`ifdef DATAMEM_COPY_CHECKSUM_EN
                    chk("checksum", int'(checksum), e.csum);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tick(); tick(); tick();
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_memwrite", int'(MemWrite), 0);
        chk("rst_address", int'(Address), 0);
        chk("rst_writedata", int'(WriteData), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        preload(0, 16'h1111);
        preload(1, 16'h2222);
        preload(2, 16'h3333);
        preload(3, 16'h4444);
        push_wr(16, 16'h1111);
        push_wr(17, 16'h2222);
        push_wr(18, 16'h3333);
        push_wr(19, 16'h4444);
        push_dn(4, 4, 16'hAAAA);
        issue(0, 16, 4);
        wait_idle();
        chk("mem16", int'(mem[16]), 16'h1111);
        chk("mem19", int'(mem[19]), 16'h4444);

        push_dn(0, 0, 0);
        issue(0, 20, 0);
        wait_idle();
        chk("zero_len_mem20", int'(mem[20]), 0);
        chk("zero_len_mem0", int'(mem[0]), 16'h1111);

        preload(0, 16'h000A);
        preload(1, 16'h000B);
        preload(2, 16'h000C);
        push_wr(1, 16'h000A);
        push_wr(2, 16'h000A);
        push_wr(3, 16'h000A);
        push_dn(3, 3, 16'h001E);
        issue(0, 1, 3);
        wait_idle();
        chk("overlap_mem1", int'(mem[1]), 16'h000A);
        chk("overlap_mem3", int'(mem[3]), 16'h000A);

        preload(62, 16'h6262);
        preload(63, 16'h6363);
        push_wr(0, 16'h6262);
        push_wr(1, 16'h6363);
        push_wr(2, 16'h6262);
        push_wr(3, 16'h6363);
        push_dn(4, 4, 16'h8B8A);
        issue(62, 0, 4);
        wait_idle();
        chk("wrap_mem2", int'(mem[2]), 16'h6262);
        chk("wrap_mem3", int'(mem[3]), 16'h6363);

        push_wr(8, 16'h6262);
        push_wr(9, 16'h6363);
        push_dn(2, 2, 16'hC5C5);
        push_wr(12, 16'h6363);
        push_dn(1, 1, 16'h6363);
        issue(0, 8, 2);
        cmd_src = 16'd1;
        cmd_dst = 16'd12;
        cmd_len = 7'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        chk("accept_after_done", cyc - last_done_cyc, 1);
        tick();
        cmd_valid = 1'b0;
        wait_idle();
        chk("hs_mem12", int'(mem[12]), 16'h6363);

        for (int i = 0; i < 8; i++) preload(32 + i, 16'h3200 + i);
        push_wr(48, 16'h3200);
        push_wr(49, 16'h3201);
        issue(32, 48, 8);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_memwrite", int'(MemWrite), 0);
        chk("rst_mid_ready", int'(cmd_ready), 1);
        chk("rst_mid_done", int'(done), 0);
        reset = 1'b0;
        tick(); tick();
        chk("rst_mid_mem48", int'(mem[48]), 16'h3200);
        chk("rst_mid_mem49", int'(mem[49]), 16'h3201);
        for (int i = 50; i < 56; i++) chk("rst_mid_untouched", int'(mem[i]), 0);

        tick(); tick();
        chk("writes_left", exp_wr.size(), 0);
        chk("dones_left", exp_dn.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
